// File: rtl/scomp_stream.sv
// Streaming multi-lane signed/unsigned magnitude comparator with valid/ready handshake.
// Define SCOMP_MINMAX_EN to compile in the per-lane running min/max trackers.
module scomp_stream #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned LANES     = 1
) (
    input  logic                       Clk,
    input  logic                       Rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       signed_mode,
    input  logic [LANES*DATAWIDTH-1:0] a,
    input  logic [LANES*DATAWIDTH-1:0] b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES-1:0]           gt,
    output logic [LANES-1:0]           lt,
    output logic [LANES-1:0]           eq
`ifdef SCOMP_MINMAX_EN
    ,
    input  logic                       clr,
    output logic [LANES*DATAWIDTH-1:0] min_o,
    output logic [LANES*DATAWIDTH-1:0] max_o,
    output logic                       mm_valid
`endif
);

    // Differing MSBs decide a signed compare outright; otherwise plain magnitude.
    function automatic logic less(input logic [DATAWIDTH-1:0] x,
                                  input logic [DATAWIDTH-1:0] y,
                                  input logic                 sgn);
        if (sgn && (x[DATAWIDTH-1] != y[DATAWIDTH-1]))
            return x[DATAWIDTH-1];
        return (x < y);
    endfunction

    logic                 accept;
    logic                 out_valid_q, out_valid_d;
    logic [LANES-1:0]     gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [DATAWIDTH-1:0] a_l, b_l;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        a_l         = '0;
        b_l         = '0;
        if (accept) begin
            out_valid_d = 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
                a_l     = a[i*DATAWIDTH +: DATAWIDTH];
                b_l     = b[i*DATAWIDTH +: DATAWIDTH];
                lt_d[i] = less(a_l, b_l, signed_mode);
                gt_d[i] = less(b_l, a_l, signed_mode);
                eq_d[i] = (a_l == b_l);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            gt_q        <= '0;
            lt_q        <= '0;
            eq_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
        end
    end

    assign out_valid = out_valid_q;
    assign gt        = gt_q;
    assign lt        = lt_q;
    assign eq        = eq_q;

`ifdef SCOMP_MINMAX_EN
    logic                       mm_valid_q, mm_valid_d;
    logic [LANES*DATAWIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [DATAWIDTH-1:0]       s_l, mn_l, mx_l;

    // A clear coinciding with an accept makes that sample the first one.
    always_comb begin
        mm_valid_d = mm_valid_q;
        min_d      = min_q;
        max_d      = max_q;
        s_l        = '0;
        mn_l       = '0;
        mx_l       = '0;
        if (clr)
            mm_valid_d = 1'b0;
        if (accept) begin
            mm_valid_d = 1'b1;
            for (int unsigned i = 0; i < LANES; i++) begin
                s_l  = a[i*DATAWIDTH +: DATAWIDTH];
                mn_l = min_q[i*DATAWIDTH +: DATAWIDTH];
                mx_l = max_q[i*DATAWIDTH +: DATAWIDTH];
                if (!mm_valid_q || clr) begin
                    min_d[i*DATAWIDTH +: DATAWIDTH] = s_l;
                    max_d[i*DATAWIDTH +: DATAWIDTH] = s_l;
                end else begin
                    if (less(s_l, mn_l, signed_mode))
                        min_d[i*DATAWIDTH +: DATAWIDTH] = s_l;
                    if (less(mx_l, s_l, signed_mode))
                        max_d[i*DATAWIDTH +: DATAWIDTH] = s_l;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mm_valid_q <= 1'b0;
            min_q      <= '0;
            max_q      <= '0;
        end else begin
            mm_valid_q <= mm_valid_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end

    assign mm_valid = mm_valid_q;
    assign min_o    = min_q;
    assign max_o    = max_q;
`endif

endmodule
